// File: rtl/morse_char_assembler_pkg.sv
// Shared definitions for the Morse decode chain. The symbol codes and ASCII
// constants live here so the dit/dah decoder and the character assembler use
// the same encoding.
package morse_char_assembler_pkg;

   // Symbol stream from the dit/dah decoder (3-bit codes).
   typedef enum logic [2:0] {
      SYM_WAIT  = 3'd0,
      SYM_DIT   = 3'd1,
      SYM_DAH   = 3'd2,
      SYM_GAP   = 3'd3,
      SYM_SPACE = 3'd4
   } sym_e;

   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

   localparam int MAX_SYMS_DEFAULT = 6;

   // Codes 5-7 are not defined upstream and are treated as idle.
   function automatic sym_e decode_sym(input logic [2:0] code);
      return (code <= 3'd4) ? sym_e'(code) : SYM_WAIT;
   endfunction

endpackage

// File: rtl/morse_lut.sv
// Morse pattern to ASCII translation. The first symbol received sits at bit
// len-1 of the pattern; a dah is 1 and a dit is 0. Unused upper pattern bits
// are zero by construction. Anything not in the table maps to '?'.
module morse_lut
   import morse_char_assembler_pkg::*;
#(
   parameter int MAX_SYMS = MAX_SYMS_DEFAULT
) (
   input  logic [MAX_SYMS-1:0] pattern,
   input  logic [2:0]          len,
   output logic [7:0]          ascii
);

   logic [5:0] p6;

   // Normalise the pattern to the six bits the table is written against.
   always_comb p6 = 6'(pattern);

   // Table lookup keyed first on length, then on the dit/dah pattern.
   // NOTE: ascii gets a default before the case so no path leaves it
   // unassigned; that keeps this purely combinational with no latch.
   always_comb begin
      ascii = ASCII_UNKNOWN;
      case (len)
         3'd1: case (p6)
            6'b000000: ascii = "E";
            6'b000001: ascii = "T";
            default:   ascii = ASCII_UNKNOWN;
         endcase
         3'd2: case (p6)
            6'b000000: ascii = "I";
            6'b000001: ascii = "A";
            6'b000010: ascii = "N";
            6'b000011: ascii = "M";
            default:   ascii = ASCII_UNKNOWN;
         endcase
         3'd3: case (p6)
            6'b000000: ascii = "S";
            6'b000001: ascii = "U";
            6'b000010: ascii = "R";
            6'b000011: ascii = "W";
            6'b000100: ascii = "D";
            6'b000101: ascii = "K";
            6'b000110: ascii = "G";
            6'b000111: ascii = "O";
            default:   ascii = ASCII_UNKNOWN;
         endcase
         3'd4: case (p6)
            6'b000000: ascii = "H";
            6'b000001: ascii = "V";
            6'b000010: ascii = "F";
            6'b000100: ascii = "L";
            6'b000110: ascii = "P";
            6'b000111: ascii = "J";
            6'b001000: ascii = "B";
            6'b001001: ascii = "X";
            6'b001010: ascii = "C";
            6'b001011: ascii = "Y";
            6'b001100: ascii = "Z";
            6'b001101: ascii = "Q";
            default:   ascii = ASCII_UNKNOWN;
         endcase
         3'd5: case (p6)
            6'b011111: ascii = "0";
            6'b001111: ascii = "1";
            6'b000111: ascii = "2";
            6'b000011: ascii = "3";
            6'b000001: ascii = "4";
            6'b000000: ascii = "5";
            6'b010000: ascii = "6";
            6'b011000: ascii = "7";
            6'b011100: ascii = "8";
            6'b011110: ascii = "9";
            default:   ascii = ASCII_UNKNOWN;
         endcase
         3'd6: case (p6)
            6'b010101: ascii = ".";
            6'b110011: ascii = ",";
            6'b001100: ascii = "?";
            default:   ascii = ASCII_UNKNOWN;
         endcase
         default: ascii = ASCII_UNKNOWN;
      endcase
   end

endmodule

// File: rtl/morse_char_assembler.sv
// Collects dits and dahs from the symbol stream into a pattern, translates
// it to ASCII on GAP or SPACE, adds a space character at word ends, and
// hands the characters out through a small valid/ready FIFO.
module morse_char_assembler
   import morse_char_assembler_pkg::*;
#(
   parameter int MAX_SYMS   = MAX_SYMS_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] ditsdahs,
   output logic [7:0] char_data,
   output logic       char_valid,
   input  logic       char_ready,
   output logic [2:0] sym_count,
   output logic       overflow
);

   localparam int         AW    = $clog2(FIFO_DEPTH);
   localparam int         CW    = AW + 1;
   localparam logic [2:0] SYM_MAX = 3'(MAX_SYMS);

   sym_e                sym;
   logic [MAX_SYMS-1:0] pattern;
   logic                too_long;
   logic                pending_space;
   logic [7:0]          lut_ascii;
   logic [7:0]          char_code;

   logic                push_req;
   logic [7:0]          push_data;
   logic                do_push;
   logic                pop;
   logic                full;

   logic [7:0]          mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;

   morse_lut #(.MAX_SYMS(MAX_SYMS)) u_lut (
      .pattern (pattern),
      .len     (sym_count),
      .ascii   (lut_ascii)
   );

   // Map the raw input code onto the symbol set, undefined codes are idle.
   always_comb sym = decode_sym(ditsdahs);

   // Finished character: overlong input always reads as unknown.
   always_comb char_code = too_long ? ASCII_UNKNOWN : lut_ascii;

   // Decide what, if anything, enters the FIFO this cycle. A deferred word
   // space always owns the cycle; in that cycle sym_count is zero, so a
   // GAP or SPACE there cannot also produce a character.
   always_comb begin
      push_req  = 1'b0;
      push_data = ASCII_SPACE;
      if (pending_space) begin
         push_req  = 1'b1;
         push_data = ASCII_SPACE;
      end else if (sym == SYM_GAP || sym == SYM_SPACE) begin
         if (sym_count != 3'd0) begin
            push_req  = 1'b1;
            push_data = char_code;
         end else if (sym == SYM_SPACE) begin
            push_req  = 1'b1;
            push_data = ASCII_SPACE;
         end
      end
   end

   always_comb begin
      char_valid = (count != '0);
      full       = (count == CW'(FIFO_DEPTH));
      pop        = char_valid && char_ready;
      do_push    = push_req && (!full || pop);
      char_data  = char_valid ? mem[rd_ptr] : 8'h00;
   end

   // Pattern accumulation and character boundary handling.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern       <= '0;
         sym_count     <= 3'd0;
         too_long      <= 1'b0;
         pending_space <= 1'b0;
      end else begin
         case (sym)
            SYM_DIT, SYM_DAH: begin
               if (sym_count == SYM_MAX) begin
                  too_long <= 1'b1;
               end else begin
                  pattern   <= {pattern[MAX_SYMS-2:0], (sym == SYM_DAH)};
                  sym_count <= sym_count + 3'd1;
               end
            end
            SYM_GAP, SYM_SPACE: begin
               if (sym_count != 3'd0) begin
                  pattern   <= '0;
                  sym_count <= 3'd0;
                  too_long  <= 1'b0;
               end
            end
            default: ;
         endcase
         // A space is deferred one cycle when the same edge already carries
         // a character or an earlier deferred space.
         pending_space <= (sym == SYM_SPACE) &&
                          ((sym_count != 3'd0) || pending_space);
      end
   end

   // FIFO pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         if (push_req && full && !pop) overflow <= 1'b1;
      end
   end

   // FIFO storage.
   // NOTE: the memory array has no reset; emptiness is tracked by count and
   // char_data is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: tb/tb_morse_char_assembler.sv
// Directed bench for morse_char_assembler. Expected characters are queued
// when their terminating symbol is driven and compared as the DUT hands
// them out.
module tb_morse_char_assembler;
   import morse_char_assembler_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] ditsdahs;
   logic [7:0] char_data;
   logic       char_valid;
   logic       char_ready;
   logic [2:0] sym_count;
   logic       overflow;

   int compared   = 0;
   int mismatched = 0;
   int beats      = 0;
   int cycle      = 0;
   int b0;
   logic [7:0] sb [$];
   int         beat_cyc [$];

   morse_char_assembler #(.MAX_SYMS(6), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ditsdahs   (ditsdahs),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .sym_count  (sym_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   // Output monitor: a beat is taken at the next rising edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && char_valid === 1'b1 && char_ready === 1'b1) begin
         beats++;
         beat_cyc.push_back(cycle);
         if (sb.size() == 0) check("unexpected_beat", char_data, 8'h00 ^ ~char_data);
         else                check("char_data", char_data, sb.pop_front());
      end
   end

   task automatic send(input sym_e s);
      ditsdahs = s;
      @(posedge clk);
      #1;
      ditsdahs = SYM_WAIT;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_char(input string pat, input logic [7:0] exp, input bit expect_push);
      for (int i = 0; i < pat.len(); i++) send((pat[i] == "-") ? SYM_DAH : SYM_DIT);
      if (expect_push) sb.push_back(exp);
      send(SYM_GAP);
   endtask

   task automatic drain(input string tag, input int max_cycles);
      int n = 0;
      while ((sb.size() != 0 || char_valid) && n < max_cycles) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, 8'((sb.size() == 0) && !char_valid), 8'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      char_ready = 1'b0;
      ditsdahs   = SYM_WAIT;
      #2;
      check("reset_valid", 8'(char_valid), 8'd0);
      check("reset_data", char_data, 8'h00);
      check("reset_sym_count", 8'(sym_count), 8'd0);
      check("reset_overflow", 8'(overflow), 8'd0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      char_ready = 1'b1;

      // Letter A: one beat, sym_count back to zero.
      b0 = beats;
      send(SYM_DIT);
      send(SYM_DAH);
      check("a_sym_count", 8'(sym_count), 8'd2);
      sb.push_back(8'h41);
      send(SYM_GAP);
      check("a_sym_cleared", 8'(sym_count), 8'd0);
      idle(3);
      check("a_one_beat", 8'(beats - b0), 8'd1);

      // B then SPACE: two beats on adjacent cycles.
      beat_cyc.delete();
      send(SYM_DAH); send(SYM_DIT); send(SYM_DIT); send(SYM_DIT);
      sb.push_back(8'h42);
      sb.push_back(ASCII_SPACE);
      send(SYM_SPACE);
      idle(4);
      check("b_space_beats", 8'(beat_cyc.size()), 8'd2);
      if (beat_cyc.size() >= 2)
         check("b_space_adjacent", 8'(beat_cyc[1] - beat_cyc[0]), 8'd1);

      // SPACE with an empty buffer: single 0x20.
      b0 = beats;
      sb.push_back(ASCII_SPACE);
      send(SYM_SPACE);
      idle(3);
      check("lone_space_beats", 8'(beats - b0), 8'd1);

      // E followed by two back-to-back SPACEs: E, space, space.
      b0 = beats;
      send(SYM_DIT);
      sb.push_back(8'h45);
      sb.push_back(ASCII_SPACE);
      sb.push_back(ASCII_SPACE);
      send(SYM_SPACE);
      send(SYM_SPACE);
      idle(4);
      check("e_two_spaces_beats", 8'(beats - b0), 8'd3);

      // Seven dits: saturates at six, then '?'.
      repeat (7) send(SYM_DIT);
      check("too_long_sat", 8'(sym_count), 8'd6);
      sb.push_back(ASCII_UNKNOWN);
      send(SYM_GAP);
      idle(3);

      // Five dits and a dah: unknown six-symbol pattern.
      send_char(".....-", ASCII_UNKNOWN, 1'b1);
      idle(3);

      // Backpressure: fifth character is dropped and overflow sticks.
      char_ready = 1'b0;
      send_char(".",  8'h45, 1'b1);
      send_char("-",  8'h54, 1'b1);
      send_char("..", 8'h49, 1'b1);
      send_char("--", 8'h4D, 1'b1);
      check("full_no_overflow_yet", 8'(overflow), 8'd0);
      send_char(".-", 8'h41, 1'b0);
      check("overflow_set", 8'(overflow), 8'd1);
      char_ready = 1'b1;
      drain("overflow_drain", 20);
      check("overflow_sticky", 8'(overflow), 8'd1);

      // Async reset mid-pattern with a queued character.
      char_ready = 1'b0;
      send_char(".", 8'h45, 1'b1);
      send(SYM_DIT);
      send(SYM_DAH);
      check("pre_reset_valid", 8'(char_valid), 8'd1);
      check("pre_reset_sym_count", 8'(sym_count), 8'd2);
      #3 rst_n = 1'b0;
      #1;
      check("async_valid", 8'(char_valid), 8'd0);
      check("async_sym_count", 8'(sym_count), 8'd0);
      check("async_overflow", 8'(overflow), 8'd0);
      check("async_data", char_data, 8'h00);
      sb.delete();
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      char_ready = 1'b1;
      b0 = beats;
      send(SYM_GAP);
      idle(3);
      check("post_reset_gap_silent", 8'(beats - b0), 8'd0);

      // Full FIFO with a push and a pop on the same edge.
      char_ready = 1'b0;
      send_char(".",  8'h45, 1'b1);
      send_char("-",  8'h54, 1'b1);
      send_char("..", 8'h49, 1'b1);
      send_char("--", 8'h4D, 1'b1);
      send(SYM_DIT); send(SYM_DIT); send(SYM_DIT);
      sb.push_back(8'h53);
      char_ready = 1'b1;
      send(SYM_GAP);
      check("push_pop_no_overflow", 8'(overflow), 8'd0);
      drain("push_pop_drain", 20);
      check("push_pop_overflow_final", 8'(overflow), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
